alu_share_arbiter: RTL and testbench
====================================

Name: alu_share_arbiter

Overview:
Shares one combinational ALU instance between two requesters: port 0 is the core execute path and port 1 is the debug/CSR helper. Each port uses a valid/ready request channel and a valid/ready response channel. At most one operation is outstanding. The result is registered and held until the owning requester accepts it. Round-robin arbitration prevents starvation.

Parameters:
DATA_W, 32, operand/result width (ALU is instantiated at this width)
OP_W, 4, ALU control width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
req0_valid  in  1  port 0 request present
req0_ready  out  1  port 0 request accepted this cycle
req0_op1  in  DATA_W  port 0 operand 1
req0_op2  in  DATA_W  port 0 operand 2
req0_ctrl  in  OP_W  port 0 ALU control code
rsp0_valid  out  1  port 0 response available
rsp0_ready  in  1  port 0 consumes response
req1_valid / req1_ready / req1_op1 / req1_op2 / req1_ctrl  same as port 0, for port 1
rsp1_valid / rsp1_ready  same as port 0, for port 1
rsp_result  out  DATA_W  registered ALU result, shared by both response channels
rsp_zero  out  1  registered isZero
rsp_err  out  1  registered illegal-ctrl flag

Behaviour:
- Legal ctrl codes: AND 0000, OR 0001, ADD 0010, SUB 0011, XOR 0100, SLL 0101, SRL 0110, SRA 0111, SLT 1000, SLTU 1001.
- Codes 1010-1111 are illegal: result forced to 0, zero=1, err=1. The ALU output is ignored for these codes.
- States:
  - IDLE: no response pending.
  - RESP: response held for owner (owner register = 0/1).
- "free" = (state==IDLE) or (state==RESP and rsp_owner_valid and rsp_owner_ready).
- Grant, combinational, evaluated only when free:
  - Only one reqN_valid high: grant N.
  - Both high: grant the port that is not last_grant.
  - reqN_ready = free & grant==N. Never assert both readies in one cycle.
- On accept (reqN_valid & reqN_ready):
  - Drive the ALU from the port-N operands.
  - Capture result/zero/err into registers; set owner=N, last_grant=N.
  - Next state RESP. rspN_valid is high the following cycle (latency 1).
- RESP:
  - rsp_owner_valid=1; the other rsp_valid=0.
  - Registers hold stable while rsp_ready is low.
  - On rsp handshake with no new accept: go to IDLE.
  - On rsp handshake with a new accept in the same cycle: stay RESP with new data. Back-to-back throughput is 1 op/cycle.
- Operand/ctrl inputs are sampled only in the accept cycle. Changes while not granted have no effect.
- Requester valid may drop before ready without protocol error. No request is latched.
- Reset values:
  - state=IDLE, rsp0_valid=rsp1_valid=0, rsp_result=0, rsp_zero=0, rsp_err=0.
  - owner=0, last_grant=1, so port 0 wins the first tie.
  - req*_ready=0 during the reset cycle.
- Reset mid-operation: a pending response is discarded and no rsp_valid is seen after reset. An accept in the same cycle as reset is dropped.
- Width rules:
  - Shifts use op2[4:0].
  - SLT is signed and SLTU unsigned; both produce a 0/1 result.
  - ADD/SUB wrap modulo 2^DATA_W.

Decomposition:
- Shared package alu_pkg: ALU control code constants (AND..SLTU), OP_W, the illegal-code predicate, and the state encoding (IDLE, RESP).
- Sub-module rr_arb2: 2-input round-robin grant with a last_grant input; purely combinational.
- The existing ALU module is instantiated once, unchanged.

Test Plan:
- Port 0 ADD 15,10 with rsp0_ready=1 -> req0_ready same cycle; rsp0_valid next cycle; result=25, zero=0, err=0; rsp1_valid stays 0.
- Port 1 SRA 0xFFFF_FF80,5 -> result 0xFFFF_FFFC; then SUB 7,7 -> result 0, zero=1.
- Both ports valid every cycle, rsp_ready=1 -> grants alternate 0,1,0,1 starting with port 0; one result per cycle; each result matches its own operands.
- Port 0 ADD 1,2, rsp0_ready held low 5 cycles -> result 3 stable; req1_ready=0 throughout; after rsp0_ready, port 1 is accepted in the same cycle.
- Port 0 ctrl=4'b1100, operands 5,5 -> result 0, zero=1, err=1; next legal op gives err=0.
- Accept port 0 op, assert reset in the RESP cycle -> rsp0_valid=0 and registers 0 next cycle; port 0 wins the first tie after reset.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, illegal-code predicate and arbiter state encoding
package alu_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] ALU_AND  = 4'b0000;
    localparam logic [OP_W-1:0] ALU_OR   = 4'b0001;
    localparam logic [OP_W-1:0] ALU_ADD  = 4'b0010;
    localparam logic [OP_W-1:0] ALU_SUB  = 4'b0011;
    localparam logic [OP_W-1:0] ALU_XOR  = 4'b0100;
    localparam logic [OP_W-1:0] ALU_SLL  = 4'b0101;
    localparam logic [OP_W-1:0] ALU_SRL  = 4'b0110;
    localparam logic [OP_W-1:0] ALU_SRA  = 4'b0111;
    localparam logic [OP_W-1:0] ALU_SLT  = 4'b1000;
    localparam logic [OP_W-1:0] ALU_SLTU = 4'b1001;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } arb_state_e;

    function automatic logic is_illegal_ctrl(input logic [OP_W-1:0] ctrl);
        return (ctrl > ALU_SLTU);
    endfunction

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - combinational ALU: logic, add/sub, shifts, set-less-than
module alu #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [OP_W-1:0]   ctrl_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);
    import alu_pkg::*;

    localparam int SHAMT_W = $clog2(DATA_W);

    logic [SHAMT_W-1:0] shamt;
    logic               lt_s;
    logic               lt_u;

    assign shamt = b_i[SHAMT_W-1:0];
    assign lt_s  = ($signed(a_i) < $signed(b_i));
    assign lt_u  = (a_i < b_i);

    // Operation select; unknown codes yield zero
    always_comb begin
        result_o = '0;
        case (ctrl_i)
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_ADD:  result_o = a_i + b_i;
            ALU_SUB:  result_o = a_i - b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = DATA_W'($signed(a_i) >>> shamt);
            ALU_SLT:  result_o = {{(DATA_W-1){1'b0}}, lt_s};
            ALU_SLTU: result_o = {{(DATA_W-1){1'b0}}, lt_u};
            default:  result_o = '0;
        endcase
    end

    assign zero_o = (result_o == '0);

endmodule

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-input round-robin grant, favours the port not granted last
module rr_arb2 (
    input  logic valid0_i,
    input  logic valid1_i,
    input  logic last_grant_i,
    output logic gnt0_o,
    output logic gnt1_o
);
    // A lone requester always wins; on a tie the port opposite last_grant wins
    always_comb begin
        gnt0_o = valid0_i & (~valid1_i | last_grant_i);
        gnt1_o = valid1_i & (~valid0_i | ~last_grant_i);
    end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - one ALU shared by two valid/ready requesters, one op outstanding
module alu_share_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [DATA_W-1:0] req0_op1,
    input  logic [DATA_W-1:0] req0_op2,
    input  logic [OP_W-1:0]   req0_ctrl,
    output logic              rsp0_valid,
    input  logic              rsp0_ready,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [DATA_W-1:0] req1_op1,
    input  logic [DATA_W-1:0] req1_op2,
    input  logic [OP_W-1:0]   req1_ctrl,
    output logic              rsp1_valid,
    input  logic              rsp1_ready,
    output logic [DATA_W-1:0] rsp_result,
    output logic              rsp_zero,
    output logic              rsp_err
);
    import alu_pkg::*;

    arb_state_e        state_q;
    logic              owner_q;
    logic              last_grant_q;
    logic              rsp0_valid_q;
    logic              rsp1_valid_q;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;
    logic              err_q;

    logic              owner_rsp_ready;
    logic              free;
    logic              gnt0;
    logic              gnt1;
    logic              accept;
    logic              sel;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_ctrl;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              illegal;
    logic [DATA_W-1:0] result_d;
    logic              zero_d;
    logic              err_d;

    rr_arb2 u_arb (
        .valid0_i     (req0_valid),
        .valid1_i     (req1_valid),
        .last_grant_i (last_grant_q),
        .gnt0_o       (gnt0),
        .gnt1_o       (gnt1)
    );

    // The slot frees up when idle or when the held response is consumed this cycle
    always_comb begin
        owner_rsp_ready = owner_q ? rsp1_ready : rsp0_ready;
        free            = (state_q == ST_IDLE) || ((state_q == ST_RESP) && owner_rsp_ready);
        req0_ready      = free & gnt0 & ~reset;
        req1_ready      = free & gnt1 & ~reset;
        accept          = (req0_valid & req0_ready) | (req1_valid & req1_ready);
        sel             = gnt1;
    end

    // Steer the granted port's operands into the shared ALU
    always_comb begin
        alu_a    = sel ? req1_op1  : req0_op1;
        alu_b    = sel ? req1_op2  : req0_op2;
        alu_ctrl = sel ? req1_ctrl : req0_ctrl;
    end

    alu #(
        .DATA_W (DATA_W),
        .OP_W   (OP_W)
    ) u_alu (
        .a_i      (alu_a),
        .b_i      (alu_b),
        .ctrl_i   (alu_ctrl),
        .result_o (alu_result),
        .zero_o   (alu_zero)
    );

    // Illegal codes override the ALU output with a zero result and the error flag
    always_comb begin
        illegal  = is_illegal_ctrl(alu_ctrl);
        result_d = illegal ? '0   : alu_result;
        zero_d   = illegal ? 1'b1 : alu_zero;
        err_d    = illegal;
    end

    // Response FSM: capture on accept, release to IDLE on an unpaired response handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            result_q     <= '0;
            zero_q       <= 1'b0;
            err_q        <= 1'b0;
        end else if (accept) begin
            state_q      <= ST_RESP;
            owner_q      <= sel;
            last_grant_q <= sel;
            rsp0_valid_q <= ~sel;
            rsp1_valid_q <= sel;
            result_q     <= result_d;
            zero_q       <= zero_d;
            err_q        <= err_d;
        end else if ((state_q == ST_RESP) && owner_rsp_ready) begin
            state_q      <= ST_IDLE;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp_result = result_q;
    assign rsp_zero   = zero_q;
    assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench for alu_share_arbiter
module tb_alu_share_arbiter;

    localparam int DATA_W = 32;
    localparam int OP_W   = 4;

    localparam logic [3:0] C_AND  = 4'b0000;
    localparam logic [3:0] C_OR   = 4'b0001;
    localparam logic [3:0] C_ADD  = 4'b0010;
    localparam logic [3:0] C_SUB  = 4'b0011;
    localparam logic [3:0] C_XOR  = 4'b0100;
    localparam logic [3:0] C_SLL  = 4'b0101;
    localparam logic [3:0] C_SRL  = 4'b0110;
    localparam logic [3:0] C_SRA  = 4'b0111;
    localparam logic [3:0] C_SLT  = 4'b1000;
    localparam logic [3:0] C_SLTU = 4'b1001;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_valid, req0_ready, rsp0_valid, rsp0_ready;
    logic              req1_valid, req1_ready, rsp1_valid, rsp1_ready;
    logic [DATA_W-1:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [OP_W-1:0]   req0_ctrl, req1_ctrl;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero, rsp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_share_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1),
        .req0_op2(req0_op2), .req0_ctrl(req0_ctrl),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1),
        .req1_op2(req1_op2), .req1_ctrl(req1_ctrl),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic drive0(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        req0_valid = v; req0_ctrl = c; req0_op1 = a; req0_op2 = b;
    endtask

    task automatic drive1(input logic v, input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        req1_valid = v; req1_ctrl = c; req1_op1 = a; req1_op2 = b;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive0(1'b1, C_ADD, 32'd1, 32'd1);
        drive1(1'b1, C_ADD, 32'd2, 32'd2);
        mid();
        checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready: got %b exp 0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready: got %b exp 0", req1_ready); end
        step();
        step();
        checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp0_valid: got %b exp 0", rsp0_valid); end
        checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp1_valid: got %b exp 0", rsp1_valid); end
        checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h exp 0", rsp_result); end
        checks++; if ({rsp_zero, rsp_err} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b exp 00", {rsp_zero, rsp_err}); end
        drive0(1'b0, C_AND, 32'd0, 32'd0);
        drive1(1'b0, C_AND, 32'd0, 32'd0);
        reset = 1'b0;
        step();
    endtask

    task automatic test_port0_add();
        rsp0_ready = 1'b1;
        drive0(1'b1, C_ADD, 32'd15, 32'd10);
        mid();
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL add_req0_ready: got %b exp 1", req0_ready); end
        checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL add_rsp0_early: got %b exp 0", rsp0_valid); end
        step();
        drive0(1'b0, C_AND, 32'd0, 32'd0);
        checks++; if (rsp0_valid !== 1'b1) begin errors++; $display("FAIL add_rsp0_valid: got %b exp 1", rsp0_valid); end
        checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL add_rsp1_valid: got %b exp 0", rsp1_valid); end
        checks++; if (rsp_result !== 32'd25) begin errors++; $display("FAIL add_result: got %0d exp 25", rsp_result); end
        checks++; if ({rsp_zero, rsp_err} !== 2'b00) begin errors++; $display("FAIL add_flags: got %b exp 00", {rsp_zero, rsp_err}); end
        step();
        checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL add_rsp0_drop: got %b exp 0", rsp0_valid); end
    endtask

    task automatic test_port1_sra_sub();
        rsp1_ready = 1'b1;
        drive1(1'b1, C_SRA, 32'hFFFF_FF80, 32'd5);
        mid();
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL sra_req1_ready: got %b exp 1", req1_ready); end
        step();
        checks++; if (rsp1_valid !== 1'b1) begin errors++; $display("FAIL sra_rsp1_valid: got %b exp 1", rsp1_valid); end
        checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL sra_rsp0_valid: got %b exp 0", rsp0_valid); end
        checks++; if (rsp_result !== 32'hFFFF_FFFC) begin errors++; $display("FAIL sra_result: got %h exp fffffffc", rsp_result); end
        drive1(1'b1, C_SUB, 32'd7, 32'd7);
        mid();
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL sub_req1_ready: got %b exp 1", req1_ready); end
        step();
        drive1(1'b0, C_AND, 32'd0, 32'd0);
        checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL sub_result: got %h exp 0", rsp_result); end
        checks++; if ({rsp_zero, rsp_err} !== 2'b10) begin errors++; $display("FAIL sub_flags: got %b exp 10", {rsp_zero, rsp_err}); end
        step();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        reset = 1'b1;
        step();
        reset = 1'b0;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive0(1'b1, C_ADD, 32'(i), 32'd100);
            drive1(1'b1, C_SUB, 32'd100, 32'(i));
            mid();
            if (i % 2 == 0) begin
                exp = 32'(i) + 32'd100;
                checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL b2b_ready_%0d: got %b exp 10", i, {req0_ready, req1_ready}); end
                step();
                checks++; if ({rsp0_valid, rsp1_valid} !== 2'b10) begin errors++; $display("FAIL b2b_rsp_%0d: got %b exp 10", i, {rsp0_valid, rsp1_valid}); end
            end else begin
                exp = 32'd100 - 32'(i);
                checks++; if ({req0_ready, req1_ready} !== 2'b01) begin errors++; $display("FAIL b2b_ready_%0d: got %b exp 01", i, {req0_ready, req1_ready}); end
                step();
                checks++; if ({rsp0_valid, rsp1_valid} !== 2'b01) begin errors++; $display("FAIL b2b_rsp_%0d: got %b exp 01", i, {rsp0_valid, rsp1_valid}); end
            end
            checks++; if (rsp_result !== exp) begin errors++; $display("FAIL b2b_result_%0d: got %0d exp %0d", i, rsp_result, exp); end
        end
        drive0(1'b0, C_AND, 32'd0, 32'd0);
        drive1(1'b0, C_AND, 32'd0, 32'd0);
        step();
    endtask

    task automatic test_stall();
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b1;
        drive0(1'b1, C_ADD, 32'd1, 32'd2);
        mid();
        checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL stall_req0_ready: got %b exp 1", req0_ready); end
        step();
        drive0(1'b0, C_AND, 32'd0, 32'd0);
        drive1(1'b1, C_XOR, 32'h0000_00F0, 32'h0000_000F);
        for (int i = 0; i < 5; i++) begin
            mid();
            checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL stall_req1_ready_%0d: got %b exp 0", i, req1_ready); end
            checks++; if (rsp0_valid !== 1'b1 || rsp_result !== 32'd3) begin errors++; $display("FAIL stall_hold_%0d: got valid %b result %0d exp 1/3", i, rsp0_valid, rsp_result); end
            step();
        end
        rsp0_ready = 1'b1;
        mid();
        checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready: got %b exp 1", req1_ready); end
        step();
        drive1(1'b0, C_AND, 32'd0, 32'd0);
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b01) begin errors++; $display("FAIL stall_handover: got %b exp 01", {rsp0_valid, rsp1_valid}); end
        checks++; if (rsp_result !== 32'h0000_00FF) begin errors++; $display("FAIL stall_xor_result: got %h exp ff", rsp_result); end
        step();
    endtask

    task automatic test_illegal();
        rsp0_ready = 1'b1;
        drive0(1'b1, 4'b1100, 32'd5, 32'd5);
        step();
        checks++; if (rsp_result !== 32'd0) begin errors++; $display("FAIL illegal_result: got %h exp 0", rsp_result); end
        checks++; if ({rsp_zero, rsp_err} !== 2'b11) begin errors++; $display("FAIL illegal_flags: got %b exp 11", {rsp_zero, rsp_err}); end
        drive0(1'b1, C_OR, 32'd5, 32'd2);
        step();
        drive0(1'b0, C_AND, 32'd0, 32'd0);
        checks++; if (rsp_result !== 32'd7) begin errors++; $display("FAIL legal_after_result: got %0d exp 7", rsp_result); end
        checks++; if ({rsp_zero, rsp_err} !== 2'b00) begin errors++; $display("FAIL legal_after_flags: got %b exp 00", {rsp_zero, rsp_err}); end
        step();
    endtask

    task automatic test_ops();
        logic [3:0]  c [6];
        logic [31:0] a [6];
        logic [31:0] b [6];
        logic [31:0] e [6];
        c[0] = C_SLT;  a[0] = 32'hFFFF_FFFF; b[0] = 32'd1;          e[0] = 32'd1;
        c[1] = C_SLTU; a[1] = 32'hFFFF_FFFF; b[1] = 32'd1;          e[1] = 32'd0;
        c[2] = C_SLL;  a[2] = 32'd1;         b[2] = 32'h0000_0021;  e[2] = 32'd2;
        c[3] = C_SRL;  a[3] = 32'h8000_0000; b[3] = 32'd31;         e[3] = 32'd1;
        c[4] = C_AND;  a[4] = 32'hF0F0_F0F0; b[4] = 32'h0FF0_0FF0;  e[4] = 32'h00F0_00F0;
        c[5] = C_ADD;  a[5] = 32'hFFFF_FFFF; b[5] = 32'd1;          e[5] = 32'd0;
        rsp0_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive0(1'b1, c[i], a[i], b[i]);
            step();
            checks++; if (rsp_result !== e[i] || rsp_zero !== (e[i] == 32'd0)) begin errors++; $display("FAIL ops_%0d: got %h zero %b exp %h", i, rsp_result, rsp_zero, e[i]); end
        end
        drive0(1'b0, C_AND, 32'd0, 32'd0);
        step();
    endtask

    task automatic test_reset_mid();
        rsp0_ready = 1'b0;
        drive0(1'b1, C_ADD, 32'd3, 32'd4);
        step();
        drive0(1'b0, C_AND, 32'd0, 32'd0);
        checks++; if (rsp0_valid !== 1'b1 || rsp_result !== 32'd7) begin errors++; $display("FAIL rmid_pending: got valid %b result %0d exp 1/7", rsp0_valid, rsp_result); end
        reset = 1'b1;
        rsp1_ready = 1'b1;
        drive1(1'b1, C_SUB, 32'd9, 32'd1);
        mid();
        checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL rmid_req1_ready: got %b exp 0", req1_ready); end
        step();
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b00) begin errors++; $display("FAIL rmid_rsp_valid: got %b exp 00", {rsp0_valid, rsp1_valid}); end
        checks++; if (rsp_result !== 32'd0 || {rsp_zero, rsp_err} !== 2'b00) begin errors++; $display("FAIL rmid_regs: got %h %b exp 0 00", rsp_result, {rsp_zero, rsp_err}); end
        reset = 1'b0;
        rsp0_ready = 1'b1;
        drive0(1'b1, C_XOR, 32'd6, 32'd3);
        mid();
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin errors++; $display("FAIL rmid_first_tie: got %b exp 10", {req0_ready, req1_ready}); end
        step();
        drive0(1'b0, C_AND, 32'd0, 32'd0);
        drive1(1'b0, C_AND, 32'd0, 32'd0);
        checks++; if (rsp0_valid !== 1'b1 || rsp_result !== 32'd5) begin errors++; $display("FAIL rmid_after_result: got %b %0d exp 1/5", rsp0_valid, rsp_result); end
        step();
    endtask

    initial begin
        reset = 1'b1;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        drive0(1'b0, C_AND, 32'd0, 32'd0);
        drive1(1'b0, C_AND, 32'd0, 32'd0);
        step();
        test_reset();
        test_port0_add();
        test_port1_sra_sub();
        test_back_to_back();
        test_stall();
        test_illegal();
        test_ops();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
